// File: rtl/control_unit_if.sv
// control_unit_if
// Bundles the opcode/flag inputs, the memory handshake and every datapath
// control strobe driven by control_unit.
//   master : the control FSM (reads IR/isZero/mem_ready, drives the controls)
//   slave  : the datapath/memory side (drives IR/isZero/mem_ready)
interface control_unit_if;
  logic [15:0] IR;
  logic        isZero;
  logic        mem_ready;

  logic        IR_Write;
  logic        Awrite;
  logic        Bwrite;
  logic        ALUOutWrite;
  logic        Mwrite;
  logic        reg_write;
  logic        iszero_write;
  logic        Asel;
  logic        Bsel;
  logic        ItypeSel;
  logic [2:0]  ALUcontrol;
  logic [1:0]  destAddr;
  logic [2:0]  destData;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        pc_write;
  logic        pc_sel;
  logic        halted;
  logic        mem_error;
  logic        illegal_op;

  modport master (
    input  IR, isZero, mem_ready,
    output IR_Write, Awrite, Bwrite, ALUOutWrite, Mwrite, reg_write,
           iszero_write, Asel, Bsel, ItypeSel, ALUcontrol, destAddr,
           destData, mem_req, mem_we, addr_sel, pc_write, pc_sel,
           halted, mem_error, illegal_op
  );

  modport slave (
    output IR, isZero, mem_ready,
    input  IR_Write, Awrite, Bwrite, ALUOutWrite, Mwrite, reg_write,
           iszero_write, Asel, Bsel, ItypeSel, ALUcontrol, destAddr,
           destData, mem_req, mem_we, addr_sel, pc_write, pc_sel,
           halted, mem_error, illegal_op
  );
endinterface

// File: rtl/control_unit.sv
// control_unit
// Multicycle control FSM for the accumulator datapath. Decodes the opcode in
// IR into datapath write-enables and mux selects, sequences instruction
// fetch and data accesses over the mem_req/mem_ready handshake, and guards
// every memory wait with a timeout that parks the machine in HALT.
// Ports:
//   Clock       : sole clock, rising edge
//   Reset       : asynchronous, active-high
//   bus.master  : IR/isZero/mem_ready in; all control strobes and status out
// Parameter:
//   MEM_TIMEOUT : max cycles a request may wait for mem_ready (1-255)
module control_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_MOVA = 4'h7;
  localparam logic [3:0] OP_MOVR = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // The fault fires on the cycle whose increment would make the count reach
  // MEM_TIMEOUT, so a ready on that same cycle still completes normally.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] r_state;
  logic [2:0] w_nextState;
  logic [7:0] r_waitCount;
  logic       r_memError;
  logic [3:0] w_op;
  logic       w_memPhase;
  logic       w_waiting;
  logic       w_timeout;
  logic       w_unusedIrFields;

  assign w_op       = bus.IR[15:12];
  assign w_memPhase = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_waiting  = w_memPhase && !bus.mem_ready;
  assign w_timeout  = w_waiting && (r_waitCount == TIMEOUT_LAST);

  // Register and immediate fields are consumed by the datapath, not here.
  assign w_unusedIrFields = ^bus.IR[11:0];

  assign bus.mem_error = r_memError;

  // Next-state and Moore/Mealy output decode. Everything defaults to 0 so a
  // state only lists the strobes it actually raises.
  always_comb begin
    w_nextState      = r_state;
    bus.IR_Write     = 1'b0;
    bus.Awrite       = 1'b0;
    bus.Bwrite       = 1'b0;
    bus.ALUOutWrite  = 1'b0;
    bus.Mwrite       = 1'b0;
    bus.reg_write    = 1'b0;
    bus.iszero_write = 1'b0;
    bus.Asel         = 1'b0;
    bus.Bsel         = 1'b0;
    bus.ItypeSel     = 1'b0;
    bus.ALUcontrol   = 3'd0;
    bus.destAddr     = 2'd0;
    bus.destData     = 3'd0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.addr_sel     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.halted       = 1'b0;
    bus.illegal_op   = 1'b0;

    case (r_state)
      S_IDLE: w_nextState = S_FETCH;

      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.IR_Write = 1'b1;
          bus.pc_write = 1'b1;
          w_nextState  = S_DECODE;
        end else if (w_timeout) begin
          w_nextState = S_HALT;
        end
      end

      S_DECODE: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            bus.Awrite  = 1'b1;
            bus.Asel    = 1'b1;
            bus.Bwrite  = 1'b1;
            w_nextState = S_EXEC;
          end
          OP_ADDI: begin
            bus.Awrite   = 1'b1;
            bus.Asel     = 1'b1;
            bus.Bwrite   = 1'b1;
            bus.Bsel     = 1'b1;
            bus.ItypeSel = 1'b1;
            w_nextState  = S_EXEC;
          end
          OP_LI: begin
            bus.Bwrite  = 1'b1;
            bus.Bsel    = 1'b1;
            w_nextState = S_WB;
          end
          OP_LW: begin
            bus.Bwrite  = 1'b1;
            bus.Bsel    = 1'b1;
            w_nextState = S_MEM;
          end
          // Store data comes from the accumulator, address from the
          // zero-extended immediate in B.
          OP_SW: begin
            bus.Awrite  = 1'b1;
            bus.Asel    = 1'b1;
            bus.Bwrite  = 1'b1;
            bus.Bsel    = 1'b1;
            w_nextState = S_MEM;
          end
          OP_MOVA: begin
            bus.Awrite  = 1'b1;
            bus.Asel    = 1'b1;
            w_nextState = S_WB;
          end
          OP_MOVR: begin
            bus.Bwrite  = 1'b1;
            w_nextState = S_WB;
          end
          OP_BEQZ: w_nextState = S_EXEC;
          OP_NOP:  w_nextState = S_FETCH;
          OP_HALT: w_nextState = S_HALT;
          default: begin
            bus.illegal_op = 1'b1;
            w_nextState    = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        if (w_op == OP_BEQZ) begin
          bus.pc_sel   = 1'b1;
          bus.pc_write = bus.isZero;
          w_nextState  = S_FETCH;
        end else begin
          bus.ALUOutWrite  = 1'b1;
          bus.iszero_write = 1'b1;
          case (w_op)
            OP_ADD, OP_ADDI: bus.ALUcontrol = 3'd1;
            OP_SUB:          bus.ALUcontrol = 3'd2;
            OP_OR:           bus.ALUcontrol = 3'd3;
            default:         bus.ALUcontrol = 3'd0;
          endcase
          w_nextState = S_WB;
        end
      end

      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = (w_op == OP_SW);
        if (bus.mem_ready) begin
          if (w_op == OP_SW) begin
            w_nextState = S_FETCH;
          end else begin
            bus.Mwrite  = 1'b1;
            w_nextState = S_WB;
          end
        end else if (w_timeout) begin
          w_nextState = S_HALT;
        end
      end

      S_WB: begin
        bus.reg_write = 1'b1;
        case (w_op)
          OP_MOVA: begin
            bus.destAddr = 2'd0;
            bus.destData = 3'd3;
          end
          OP_LI, OP_MOVR: begin
            bus.destAddr = 2'd1;
            bus.destData = 3'd2;
          end
          OP_LW: begin
            bus.destAddr = 2'd1;
            bus.destData = 3'd4;
          end
          default: begin
            bus.destAddr = 2'd1;
            bus.destData = 3'd0;
          end
        endcase
        w_nextState = S_FETCH;
      end

      S_HALT: bus.halted = 1'b1;

      default: w_nextState = S_IDLE;
    endcase
  end

  // State, wait counter and sticky memory-fault flag. The counter restarts
  // on every state change so each FETCH/MEM visit gets a fresh budget.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_waitCount <= 8'd0;
      r_memError  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state) begin
        r_waitCount <= 8'd0;
      end else if (w_waiting) begin
        r_waitCount <= r_waitCount + 8'd1;
      end
      if (w_timeout) begin
        r_memError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit: a table of directed instructions
// with hand-derived latencies and final-cycle strobes, a randomized
// instruction stream compared cycle by cycle against a per-instruction
// sequence model, and hand-written reset/halt/timeout sequences.
module tb_control_unit;

  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic       irWrite;
    logic       aWrite;
    logic       bWrite;
    logic       aluOutWrite;
    logic       mWrite;
    logic       regWrite;
    logic       isZeroWrite;
    logic       aSel;
    logic       bSel;
    logic       itypeSel;
    logic [2:0] aluControl;
    logic [1:0] destAddr;
    logic [2:0] destData;
    logic       memReq;
    logic       memWe;
    logic       addrSel;
    logic       pcWrite;
    logic       pcSel;
    logic       halted;
    logic       memError;
    logic       illegalOp;
  } ctl_t;

  typedef struct packed {
    logic [15:0] ir;
    logic        ready;
    logic        z;
    ctl_t        exp;
  } cyc_t;

  typedef struct {
    logic [15:0] instr;
    int          fWait;
    int          mWait;
    logic        isZero;
    int          latency;
    ctl_t        last;
  } vec_t;

  logic Clock = 1'b0;
  logic Reset;
  control_unit_if bus();

  control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  logic [15:0] curIR = 16'h0000;
  cyc_t q[$];

  function automatic ctl_t sampleOut();
    ctl_t s;
    s.irWrite     = bus.IR_Write;
    s.aWrite      = bus.Awrite;
    s.bWrite      = bus.Bwrite;
    s.aluOutWrite = bus.ALUOutWrite;
    s.mWrite      = bus.Mwrite;
    s.regWrite    = bus.reg_write;
    s.isZeroWrite = bus.iszero_write;
    s.aSel        = bus.Asel;
    s.bSel        = bus.Bsel;
    s.itypeSel    = bus.ItypeSel;
    s.aluControl  = bus.ALUcontrol;
    s.destAddr    = bus.destAddr;
    s.destData    = bus.destData;
    s.memReq      = bus.mem_req;
    s.memWe       = bus.mem_we;
    s.addrSel     = bus.addr_sel;
    s.pcWrite     = bus.pc_write;
    s.pcSel       = bus.pc_sel;
    s.halted      = bus.halted;
    s.memError    = bus.mem_error;
    s.illegalOp   = bus.illegal_op;
    return s;
  endfunction

  task automatic checkOutput(input string name, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and let the
  // combinational outputs settle before anyone samples them.
  task automatic applyStimulus(input logic [15:0] ir, input logic ready, input logic z);
    @(negedge Clock);
    bus.IR        = ir;
    bus.mem_ready = ready;
    bus.isZero    = z;
    #1;
  endtask

  // Reset asserted mid-cycle with mem_ready high; released just after a
  // rising edge so the following sampled cycle is IDLE.
  task automatic doReset();
    @(negedge Clock);
    Reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.isZero    = 1'b1;
    #1 checkOutput("reset asserted", sampleOut(), '0);
    @(negedge Clock);
    #1 checkOutput("reset held", sampleOut(), '0);
    @(posedge Clock);
    #1;
    Reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.isZero    = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic ctl_t decodeExp(input logic [3:0] op);
    ctl_t e = '0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin e.aWrite = 1; e.aSel = 1; e.bWrite = 1; end
      4'h5: begin e.aWrite = 1; e.aSel = 1; e.bWrite = 1; e.bSel = 1; e.itypeSel = 1; end
      4'h6, 4'h9: begin e.bWrite = 1; e.bSel = 1; end
      4'hA: begin e.aWrite = 1; e.aSel = 1; e.bWrite = 1; e.bSel = 1; end
      4'h7: begin e.aWrite = 1; e.aSel = 1; end
      4'h8: e.bWrite = 1;
      4'h0, 4'hB, 4'hF: e = '0;
      default: e.illegalOp = 1;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] aluCode(input logic [3:0] op);
    logic [2:0] codes [1:5];
    codes[1] = 3'd1; codes[2] = 3'd2; codes[3] = 3'd0; codes[4] = 3'd3; codes[5] = 3'd1;
    return codes[op];
  endfunction

  function automatic ctl_t wbCtl(input logic [1:0] da, input logic [2:0] dd);
    ctl_t e = '0;
    e.regWrite = 1; e.destAddr = da; e.destData = dd;
    return e;
  endfunction

  function automatic void pushCycle(input ctl_t e, input logic ready, input logic z);
    cyc_t c;
    c.ir = curIR; c.ready = ready; c.z = z; c.exp = e;
    q.push_back(c);
  endfunction

  // Appends the full expected cycle sequence of one instruction, fetch
  // included, with fw fetch wait states and mw memory wait states.
  function automatic void modelInstr(input logic [15:0] instr, input int fw, input int mw, input logic z);
    logic [3:0] op = instr[15:12];
    ctl_t e;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.memReq = 1;
      if (i == fw) begin e.irWrite = 1; e.pcWrite = 1; end
      pushCycle(e, (i == fw), z);
    end
    curIR = instr;
    pushCycle(decodeExp(op), 1'b0, z);
    if (op >= 4'h1 && op <= 4'h5) begin
      e = '0; e.aluOutWrite = 1; e.isZeroWrite = 1; e.aluControl = aluCode(op);
      pushCycle(e, 1'b0, z);
      pushCycle(wbCtl(2'd1, 3'd0), 1'b0, z);
    end else if (op == 4'h6 || op == 4'h8) begin
      pushCycle(wbCtl(2'd1, 3'd2), 1'b0, z);
    end else if (op == 4'h7) begin
      pushCycle(wbCtl(2'd0, 3'd3), 1'b0, z);
    end else if (op == 4'h9 || op == 4'hA) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.memReq = 1; e.addrSel = 1; e.memWe = (op == 4'hA);
        e.mWrite = (op == 4'h9) && (i == mw);
        pushCycle(e, (i == mw), z);
      end
      if (op == 4'h9) pushCycle(wbCtl(2'd1, 3'd4), 1'b0, z);
    end else if (op == 4'hB) begin
      e = '0; e.pcSel = 1; e.pcWrite = z;
      pushCycle(e, 1'b0, z);
    end
  endfunction

  task automatic runQueue(input string tag);
    cyc_t c;
    int n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      applyStimulus(c.ir, c.ready, c.z);
      checkOutput($sformatf("%s cyc%0d ir=%h", tag, n, c.ir), sampleOut(), c.exp);
      n++;
    end
  endtask

  // Reacts to the DUT's own requests: answers fetch after fWait waits and
  // data access after mWait waits, counting cycles until the next fetch.
  task automatic runVector(input vec_t v, output int lat, output ctl_t last);
    int fc = 0;
    int mc = 0;
    bit fetched = 0;
    bit loaded = 0;
    ctl_t cur;
    lat = 0;
    last = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge Clock);
      if (fetched && !loaded) begin
        bus.IR = v.instr;
        loaded = 1;
      end
      bus.isZero    = v.isZero;
      bus.mem_ready = 1'b0;
      #1;
      if (bus.mem_req && !bus.addr_sel) begin
        if (fetched) return;
        bus.mem_ready = (fc == v.fWait);
        fc++;
      end else if (bus.mem_req) begin
        bus.mem_ready = (mc == v.mWait);
        mc++;
      end else if (!fetched && fc == 0) begin
        continue;
      end
      #1;
      cur = sampleOut();
      lat++;
      last = cur;
      if (cur.irWrite) fetched = 1;
    end
    lat = -1;
  endtask

  task automatic timeoutCase(input bit inMem, input string tag);
    int n = 0;
    ctl_t e = '0;
    doReset();
    applyStimulus(curIR, 1'b0, 1'b0);
    if (inMem) begin
      applyStimulus(curIR, 1'b1, 1'b0);
      curIR = 16'h9006;
      applyStimulus(curIR, 1'b0, 1'b0);
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      applyStimulus(curIR, 1'b0, 1'b0);
      if (bus.halted) break;
      if (bus.mem_req) n++;
    end
    checkValue({tag, " wait cycles"}, n, MEM_TIMEOUT);
    e.halted = 1; e.memError = 1;
    checkOutput({tag, " fault"}, sampleOut(), e);
    applyStimulus(curIR, 1'b1, 1'b0);
    checkOutput({tag, " fault held"}, sampleOut(), e);
  endtask

  vec_t vecs[15];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ctl_t e;
    int lat;
    ctl_t last;
    logic [15:0] instr;
    int fw, mw;

    Reset = 1'b1;
    bus.IR = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.isZero = 1'b0;

    // Directed table: {instr, fetch waits, mem waits, isZero, latency, last cycle}.
    vecs[0]  = '{16'h1300, 0, 0, 1'b0, 4, wbCtl(2'd1, 3'd0)};
    vecs[1]  = '{16'h2100, 2, 0, 1'b0, 6, wbCtl(2'd1, 3'd0)};
    vecs[2]  = '{16'h3100, 0, 0, 1'b0, 4, wbCtl(2'd1, 3'd0)};
    vecs[3]  = '{16'h4200, 1, 0, 1'b0, 5, wbCtl(2'd1, 3'd0)};
    vecs[4]  = '{16'h50FF, 0, 0, 1'b0, 4, wbCtl(2'd1, 3'd0)};
    vecs[5]  = '{16'h6004, 0, 0, 1'b0, 3, wbCtl(2'd1, 3'd2)};
    vecs[6]  = '{16'h7800, 1, 0, 1'b0, 4, wbCtl(2'd0, 3'd3)};
    vecs[7]  = '{16'h8300, 0, 0, 1'b0, 3, wbCtl(2'd1, 3'd2)};
    vecs[8]  = '{16'h9006, 0, 3, 1'b0, 7, wbCtl(2'd1, 3'd4)};
    e = '0; e.memReq = 1; e.addrSel = 1; e.memWe = 1;
    vecs[9]  = '{16'hA006, 1, 0, 1'b0, 4, e};
    e = '0; e.pcSel = 1; e.pcWrite = 1;
    vecs[10] = '{16'hB005, 0, 0, 1'b1, 3, e};
    e = '0; e.pcSel = 1;
    vecs[11] = '{16'hB005, 2, 0, 1'b0, 5, e};
    vecs[12] = '{16'h0000, 0, 0, 1'b0, 2, ctl_t'('0)};
    e = '0; e.illegalOp = 1;
    vecs[13] = '{16'hC000, 0, 0, 1'b0, 2, e};
    vecs[14] = '{16'hD123, 1, 0, 1'b0, 3, e};

    // Reset release with zero-wait memory.
    doReset();
    applyStimulus(curIR, 1'b0, 1'b0);
    checkOutput("post-reset idle", sampleOut(), '0);
    applyStimulus(curIR, 1'b1, 1'b0);
    e = '0; e.memReq = 1; e.irWrite = 1; e.pcWrite = 1;
    checkOutput("first fetch", sampleOut(), e);

    // Directed table.
    doReset();
    for (int i = 0; i < 15; i++) begin
      runVector(vecs[i], lat, last);
      checkValue($sformatf("vec%0d ir=%h latency", i, vecs[i].instr), lat, vecs[i].latency);
      checkOutput($sformatf("vec%0d ir=%h last cycle", i, vecs[i].instr), last, vecs[i].last);
    end

    // Randomized instruction stream, including waits at the timeout edge.
    doReset();
    curIR = bus.IR;
    pushCycle('0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      instr = {4'($urandom_range(0, 14)), 12'($urandom)};
      fw = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
      modelInstr(instr, fw, mw, 1'($urandom));
    end
    runQueue("random");

    // HALT opcode parks the machine regardless of memory activity.
    doReset();
    applyStimulus(curIR, 1'b0, 1'b0);
    applyStimulus(curIR, 1'b1, 1'b0);
    curIR = 16'hF000;
    applyStimulus(curIR, 1'b0, 1'b0);
    checkOutput("halt decode", sampleOut(), '0);
    e = '0; e.halted = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(curIR, 1'($urandom), 1'($urandom));
      checkOutput($sformatf("halt hold%0d", i), sampleOut(), e);
    end

    timeoutCase(1'b0, "fetch timeout");
    timeoutCase(1'b1, "mem timeout");

    // Reset in the middle of a waiting LW: enables drop without a clock edge.
    doReset();
    applyStimulus(curIR, 1'b0, 1'b0);
    applyStimulus(curIR, 1'b1, 1'b0);
    curIR = 16'h9006;
    applyStimulus(curIR, 1'b0, 1'b0);
    e = '0; e.memReq = 1; e.addrSel = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(curIR, 1'b0, 1'b0);
      checkOutput($sformatf("lw wait%0d", i), sampleOut(), e);
    end
    #1 Reset = 1'b1;
    #1 checkOutput("reset mid-MEM", sampleOut(), '0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    applyStimulus(curIR, 1'b0, 1'b0);
    checkOutput("idle after mid-MEM reset", sampleOut(), '0);
    applyStimulus(curIR, 1'b0, 1'b0);
    e = '0; e.memReq = 1;
    checkOutput("fetch after mid-MEM reset", sampleOut(), e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
